block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
- Kernel-level scheduler sitting directly upstream of the core array.
- On a kernel start it hands block IDs 0..num_blocks-1 to free cores, one start pulse per assignment.
- Tracks per-core busy state from each core's done pulse and asserts kernel done when every block has completed.
- Consumes kernel_config_t; drives each core's start and core_block_id inputs, and takes each core's core_done bit.

Parameters:
- NUM_CORES, 2, number of cores managed; 1..16 supported.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  kernel launch request, sampled in IDLE/DONE only
- kernel_config  input  kernel_config_t  kernel descriptor; only num_blocks (data_t) is used here
- done  output  1  kernel complete, held high in DONE
- core_start  output  NUM_CORES  one-cycle start pulse per core
- core_block_id  output  NUM_CORES x data_t  block ID for each core, held stable while that core is busy
- core_done  input  NUM_CORES  per-core done pulse (early by one cycle, per core contract)

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; done=0; core_start=0; core_block_id all 0; busy mask=0; dispatched=0; completed=0.
  - Mid-run reset abandons the kernel; no further pulses are issued.
- States:
  - IDLE: on start, latch total=kernel_config.num_blocks. If total==0, go to DONE. Otherwise go to RUN with dispatched=0, completed=0, busy=0.
  - RUN, each cycle:
    - (a) Free cores: for each i with core_done[i]&&busy[i], clear busy[i] and add 1 to completed. Multiple bits in one cycle are counted by popcount. core_done[i] with busy[i]=0 is ignored.
    - (b) Dispatch: if dispatched<total, pick the lowest-index core i with busy[i]=0 as of the start of the cycle. Register core_start[i]=1, core_block_id[i]=dispatched, set busy[i], and increment dispatched.
    - (c) Exit: when completed (after the step (a) update) == total, go to DONE.
  - DONE: done=1 held. A start re-launches exactly as from IDLE, and done drops in the same cycle the new launch is latched.
- Dispatch rate and latency:
  - At most one dispatch per cycle.
  - First core_start goes high 1 cycle after the first RUN cycle, i.e. 2 cycles after start is sampled.
  - A core freed by core_done in cycle N is eligible in cycle N+1, so its next core_start is registered at the end of N+1.
- core_start is a registered one-cycle pulse and is never asserted on a busy core.
- core_block_id[i] changes only with core_start[i].
- start while in RUN is ignored; kernel_config may change freely after launch.
- Counters are data_t wide. dispatched and completed never exceed total, so there is no wrap.
- done falls to 0 only on reset or relaunch.

Decomposition:
- common_pkg holds:
  - data_t (DATA_WIDTH bits)
  - kernel_config_t (num_blocks plus base addresses and thread count used elsewhere)
  - dispatch_state_t enum {IDLE, RUN, DONE}
- Sub-module: priority_free_picker. Combinational: takes the busy mask, outputs a found flag and the lowest-free-index. It is also reusable for warp selection.
- Popcount of accepted done pulses is a package function, popcount_cores.

Test Plan:
- NUM_CORES=2, num_blocks=4; each core pulses done 5 cycles after its start -> sequence below; done rises the cycle after the fourth valid core_done.
  - core_start[0] with id 0, then core_start[1] with id 1 the next cycle.
  - Id 2 goes to the first core freed, id 3 to the other.
- num_blocks=0, start -> done=1 next cycle; core_start never asserted.
- num_blocks=3, both cores pulse core_done in the same cycle -> completed increments by 2; core 0 receives id 2 one cycle later; core 1 receives nothing.
- Spurious core_done[1] while core 1 is idle -> no change to completed or busy.
- Reset asserted mid-RUN with blocks outstanding -> next cycle all outputs 0 and state IDLE. A new start with num_blocks=1 -> core 0 gets id 0.
- In DONE, assert start with num_blocks=2 -> done drops the same cycle; ids 0 and 1 dispatched to cores 0 and 1. start pulsed during RUN has no effect.

Source files
------------

// File: rtl/common_pkg.sv
// common_pkg: shared data widths, kernel descriptor, dispatcher states and popcount helper
package common_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_CORES = 16;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef struct packed {
    data_t num_blocks;
    data_t threads_per_block;
    data_t base_a;
    data_t base_b;
    data_t base_c;
  } kernel_config_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dispatch_state_t;
  function automatic data_t popcount_cores(input logic [MAX_CORES-1:0] mask);
    popcount_cores = '0;
    for (int i = 0; i < MAX_CORES; i++) popcount_cores += data_t'(mask[i]);
  endfunction
endpackage

// File: rtl/block_dispatcher_if.sv
// block_dispatcher_if: kernel launch and per-core start/done signals between dispatcher and core array
interface block_dispatcher_if import common_pkg::*; #(parameter int NUM_CORES = 2) ();
  logic start;
  kernel_config_t kernel_config;
  logic done;
  logic [NUM_CORES-1:0] core_start;
  data_t [NUM_CORES-1:0] core_block_id;
  logic [NUM_CORES-1:0] core_done;
  modport master(output start, kernel_config, core_done, input done, core_start, core_block_id);
  modport slave(input start, kernel_config, core_done, output done, core_start, core_block_id);
endinterface

// File: rtl/priority_free_picker.sv
// priority_free_picker: lowest-index clear bit of a busy mask
module priority_free_picker #(
  parameter int NUM_CORES = 2,
  parameter int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] busy,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: hands kernel block IDs to free cores and signals kernel completion
module block_dispatcher import common_pkg::*; #(
  parameter int NUM_CORES = 2
) (
  input logic clk,
  input logic reset,
  block_dispatcher_if.slave bus
);
  localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  dispatch_state_t state_q, state_d;
  data_t total_q, total_d, dispatched_q, dispatched_d, completed_q, completed_d;
  logic [NUM_CORES-1:0] busy_q, busy_d, core_start_q, core_start_d, accepted;
  data_t [NUM_CORES-1:0] block_id_q, block_id_d;
  logic done_q, done_d, free_found;
  logic [IDX_W-1:0] free_idx;
  priority_free_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
    .busy (busy_q),
    .found(free_found),
    .idx  (free_idx)
  );
  // done pulses from cores we never started are dropped here
  assign accepted = bus.core_done & busy_q;
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    dispatched_d = dispatched_q;
    completed_d = completed_q;
    busy_d = busy_q;
    block_id_d = block_id_q;
    done_d = done_q;
    core_start_d = '0;
    if (state_q == RUN) begin
      busy_d = busy_q & ~accepted;
      completed_d = completed_q + popcount_cores(MAX_CORES'(accepted));
      // the picker sees busy_q, so a core freed this cycle waits one cycle
      if (dispatched_q < total_q && free_found) begin
        core_start_d[free_idx] = 1'b1;
        block_id_d[free_idx] = dispatched_q;
        busy_d[free_idx] = 1'b1;
        dispatched_d = dispatched_q + 1'b1;
      end
      state_d = completed_d == total_q ? DONE : RUN;
      done_d = completed_d == total_q;
    end else if (bus.start) begin
      total_d = bus.kernel_config.num_blocks;
      dispatched_d = '0;
      completed_d = '0;
      busy_d = '0;
      state_d = total_d == '0 ? DONE : RUN;
      done_d = total_d == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      dispatched_q <= '0;
      completed_q <= '0;
      busy_q <= '0;
      block_id_q <= '0;
      done_q <= 1'b0;
      core_start_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      dispatched_q <= dispatched_d;
      completed_q <= completed_d;
      busy_q <= busy_d;
      block_id_q <= block_id_d;
      done_q <= done_d;
      core_start_q <= core_start_d;
    end
  end
  assign bus.done = done_q;
  assign bus.core_start = core_start_q;
  assign bus.core_block_id = block_id_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: scoreboard bench with emulated cores and a block-level reference model
module tb_block_dispatcher;
  import common_pkg::*;
  localparam int NC = 2;
  typedef struct {int cyc; int core; int id;} disp_t;
  logic clk, reset;
  int cyc, checks, failures;
  disp_t exp_q[$];
  bit m_run, m_done;
  int m_total, m_next, m_comp;
  bit m_busy[NC];
  int m_id[NC];
  int pend[NC];
  int lat[NC];
  block_dispatcher_if #(.NUM_CORES(NC)) bus ();
  block_dispatcher #(.NUM_CORES(NC)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // reference: blocks go out in order to the lowest core that was idle at the start of the cycle
  task automatic model_step(input bit s, input int nb, input logic [NC-1:0] cd, input bit r);
    bit was_busy[NC];
    int pick;
    pick = -1;
    if (r) begin
      m_run = 0;
      m_done = 0;
      for (int i = 0; i < NC; i++) begin
        m_busy[i] = 0;
        m_id[i] = 0;
      end
    end else if (!m_run) begin
      if (s) begin
        m_total = nb;
        m_next = 0;
        m_comp = 0;
        for (int i = 0; i < NC; i++) m_busy[i] = 0;
        m_done = (nb == 0);
        m_run = (nb != 0);
      end
    end else begin
      for (int i = 0; i < NC; i++) was_busy[i] = m_busy[i];
      for (int i = 0; i < NC; i++) begin
        if (cd[i] && was_busy[i]) begin
          m_busy[i] = 0;
          m_comp++;
        end
        if (pick < 0 && !was_busy[i]) pick = i;
      end
      if (m_next < m_total && pick >= 0) begin
        exp_q.push_back('{cyc + 1, pick, m_next});
        m_busy[pick] = 1;
        m_id[pick] = m_next;
        m_next++;
      end
      if (m_comp == m_total) begin
        m_run = 0;
        m_done = 1;
      end
    end
  endtask
  task automatic step(input bit s, input int nb, input bit r, input bit noise);
    logic [NC-1:0] cd;
    kernel_config_t kc;
    cd = '0;
    @(negedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (r) pend[i] = 0;
      else if (bus.core_start[i]) pend[i] = lat[i];
      else if (pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) cd[i] = 1'b1;
      end
      if (noise && !r && !m_busy[i] && !cd[i] && $urandom_range(0, 3) == 0) cd[i] = 1'b1;
    end
    kc.num_blocks = data_t'(nb);
    kc.threads_per_block = data_t'($urandom);
    kc.base_a = data_t'($urandom);
    kc.base_b = data_t'($urandom);
    kc.base_c = data_t'($urandom);
    bus.kernel_config = kc;
    bus.start = s;
    bus.core_done = cd;
    reset = r;
    model_step(s, nb, cd, r);
  endtask
  task automatic run_kernel(input int nb, input bit noise, input int rst_after);
    step(1, nb, 0, noise);
    for (int n = 0; m_run; n++) begin
      if (n == 400) begin
        checks++;
        failures++;
        $display("FAIL kernel_timeout: still running after %0d cycles, required done", n);
        break;
      end
      if (n == rst_after) begin
        step(0, 0, 1, 0);
        return;
      end
      step(noise && $urandom_range(0, 3) == 0, $urandom_range(0, 9), 0, noise);
    end
  endtask
  always @(negedge clk) begin
    if (cyc > 0) begin
      disp_t e;
      chk("done", 32'(bus.done), 32'(m_done));
      for (int i = 0; i < NC; i++) chk("core_block_id", 32'(bus.core_block_id[i]), 32'(m_id[i]));
      for (int i = 0; i < NC; i++) begin
        if (bus.core_start[i]) begin
          if (exp_q.size() == 0) chk("unexpected_core_start", 32'(i), 32'hffff_ffff);
          else begin
            e = exp_q.pop_front();
            chk("start_core", 32'(i), 32'(e.core));
            chk("start_id", 32'(bus.core_block_id[i]), 32'(e.id));
            chk("start_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_core_start", 32'hffff_ffff, 32'(e.core));
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.core_done = '0;
    bus.kernel_config = '0;
    reset = 1'b1;
    for (int i = 0; i < NC; i++) lat[i] = 5;
    repeat (3) step(0, 0, 1, 0);
    run_kernel(4, 0, -1);
    repeat (2) step(0, 0, 0, 0);
    run_kernel(0, 0, -1);
    repeat (2) step(0, 0, 0, 0);
    lat[0] = 6;
    lat[1] = 5;
    run_kernel(3, 0, -1);
    step(0, 0, 0, 0);
    run_kernel(3, 1, -1);
    lat[0] = 5;
    run_kernel(6, 0, 4);
    run_kernel(1, 0, -1);
    run_kernel(2, 1, -1);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NC; i++) lat[i] = $urandom_range(1, 6);
      run_kernel($urandom_range(0, 9), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0 ? $urandom_range(0, 15) : -1);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 1);
    end
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    chk("pending_dispatches", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
